// File: rtl/dpu_engine_pkg.sv
// Shared types and constants for the DPU pixel engine and its requantizer.
package dpu_engine_pkg;

    typedef enum logic [1:0] {
        ACT_LINEAR = 2'd0,
        ACT_RELU   = 2'd1,
        ACT_LEAKY  = 2'd2
    } act_mode_t;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ACCUM    = 3'd1,
        S_BIAS_ACT = 3'd2,
        S_REQ      = 3'd3,
        S_OUT      = 3'd4
    } eng_state_t;

    localparam int unsigned LEAKY_SHIFT = 7;
    localparam int          RESULT_MIN  = -128;
    localparam int          RESULT_MAX  = 127;

endpackage

// File: rtl/requant_sat.sv
// Combinational requantizer: act * scale (unsigned Q.SCALE_Q), round half-up,
// arithmetic shift, saturate to int8.
module requant_sat
    import dpu_engine_pkg::*;
#(
    parameter int unsigned ACC_W   = 32,
    parameter int unsigned SCALE_Q = 16
) (
    input  logic signed [ACC_W-1:0] act,
    input  logic [15:0]             scale,
    output logic signed [7:0]       result_c
);
    localparam int unsigned P_W = ACC_W + 17;
    localparam logic signed [P_W-1:0] HALF   = P_W'(1) << (SCALE_Q - 1);
    localparam logic signed [P_W-1:0] SAT_HI = P_W'(RESULT_MAX);
    localparam logic signed [P_W-1:0] SAT_LO = P_W'(RESULT_MIN);

    logic signed [P_W-1:0] act_ext;
    logic signed [P_W-1:0] scale_ext;
    logic signed [P_W-1:0] prod;
    logic signed [P_W-1:0] rounded;
    logic signed [P_W-1:0] shifted;

    // Scale is zero-extended so it always acts as a non-negative multiplier.
    always_comb begin
        act_ext   = $signed({{(P_W - ACC_W){act[ACC_W-1]}}, act});
        scale_ext = $signed({{(P_W - 16){1'b0}}, scale});
        prod      = act_ext * scale_ext;
        rounded   = prod + HALF;
        shifted   = rounded >>> SCALE_Q;
        if (shifted > SAT_HI) begin
            result_c = 8'(RESULT_MAX);
        end else if (shifted < SAT_LO) begin
            result_c = 8'(RESULT_MIN);
        end else begin
            result_c = 8'(shifted);
        end
    end

endmodule

// File: rtl/conv_pixel_engine.sv
// Streaming int8 MAC engine: accumulates a runtime-length operand stream, then
// applies bias, activation and requantization to produce one int8 result.
module conv_pixel_engine
    import dpu_engine_pkg::*;
#(
    parameter int unsigned  MACS_MAX  = 1152,
    parameter int unsigned  ACC_W     = 32,
    parameter int unsigned  SCALE_Q   = 16,
    parameter int unsigned  LEAKY_NUM = 13,
    localparam int unsigned LEN_W     = $clog2(MACS_MAX + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_W-1:0]        mac_len,
    input  logic [1:0]              act_mode,
    input  logic signed [ACC_W-1:0] bias,
    input  logic [15:0]             scale,
    input  logic                    op_valid,
    output logic                    op_ready,
    input  logic signed [7:0]       act_in,
    input  logic signed [7:0]       w_in,
    output logic [LEN_W-1:0]        mac_index,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [7:0]       result_int8,
    output logic                    busy
);
    localparam int unsigned PROD_W = 16;
    localparam int unsigned LK_W   = ACC_W + 9;
    localparam logic signed [LK_W-1:0] LEAKY_K = LK_W'(LEAKY_NUM);

    eng_state_t              state;
    logic [LEN_W-1:0]        len_q;
    logic [1:0]              mode_q;
    logic signed [ACC_W-1:0] bias_q;
    logic [15:0]             scale_q;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] act_q;

    logic signed [PROD_W-1:0] prod_c;
    logic signed [ACC_W-1:0]  prod_ext_c;
    logic signed [ACC_W-1:0]  sum_c;
    logic signed [LK_W-1:0]   leaky_c;
    logic signed [ACC_W-1:0]  act_c;
    logic signed [7:0]        req_c;
    logic                     beat_c;
    logic                     last_beat_c;

    // Operand product, sign-extended into the wrapping accumulator.
    always_comb begin
        prod_c     = $signed({{8{act_in[7]}}, act_in}) * $signed({{8{w_in[7]}}, w_in});
        prod_ext_c = $signed({{(ACC_W - PROD_W){prod_c[PROD_W-1]}}, prod_c});
    end

    assign beat_c      = op_valid && op_ready;
    assign last_beat_c = (mac_index == len_q - LEN_W'(1));

    // Bias add wraps; leaky uses a widened product so the floor shift is exact.
    always_comb begin
        sum_c   = acc + bias_q;
        leaky_c = $signed({{(LK_W - ACC_W){sum_c[ACC_W-1]}}, sum_c}) * LEAKY_K;
        act_c   = sum_c;
        if (sum_c[ACC_W-1]) begin
            if (mode_q == ACT_RELU) begin
                act_c = '0;
            end else if (mode_q == ACT_LEAKY) begin
                act_c = ACC_W'(leaky_c >>> LEAKY_SHIFT);
            end
        end
    end

    requant_sat #(
        .ACC_W   (ACC_W),
        .SCALE_Q (SCALE_Q)
    ) u_requant (
        .act      (act_q),
        .scale    (scale_q),
        .result_c (req_c)
    );

    // Job sequencer; all handshake and status outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            len_q       <= '0;
            mode_q      <= '0;
            bias_q      <= '0;
            scale_q     <= '0;
            acc         <= '0;
            act_q       <= '0;
            mac_index   <= '0;
            op_ready    <= 1'b0;
            out_valid   <= 1'b0;
            result_int8 <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_q     <= mac_len;
                        mode_q    <= act_mode;
                        bias_q    <= bias;
                        scale_q   <= scale;
                        acc       <= '0;
                        mac_index <= '0;
                        busy      <= 1'b1;
                        if (mac_len == '0) begin
                            state <= S_BIAS_ACT;
                        end else begin
                            state    <= S_ACCUM;
                            op_ready <= 1'b1;
                        end
                    end
                end
                S_ACCUM: begin
                    if (beat_c) begin
                        acc       <= acc + prod_ext_c;
                        mac_index <= mac_index + LEN_W'(1);
                        if (last_beat_c) begin
                            state    <= S_BIAS_ACT;
                            op_ready <= 1'b0;
                        end
                    end
                end
                S_BIAS_ACT: begin
                    act_q <= act_c;
                    state <= S_REQ;
                end
                S_REQ: begin
                    result_int8 <= req_c;
                    out_valid   <= 1'b1;
                    state       <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    op_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_pixel_engine.sv
// Self-checking bench for conv_pixel_engine: directed and randomized jobs
// compared against an arithmetic model of the int8 MAC/bias/activation/requant.
module tb_conv_pixel_engine;
    import dpu_engine_pkg::*;

    localparam int unsigned MACS_MAX  = 1152;
    localparam int unsigned ACC_W     = 32;
    localparam int unsigned SCALE_Q   = 16;
    localparam int unsigned LEAKY_NUM = 13;
    localparam int unsigned LEN_W     = $clog2(MACS_MAX + 1);
    // Closest representable value to 1.0 in an unsigned Q0.16 scale.
    localparam int          SCALE_ONE = 'hFFFF;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [LEN_W-1:0]        mac_len;
    logic [1:0]              act_mode;
    logic signed [ACC_W-1:0] bias;
    logic [15:0]             scale;
    logic                    op_valid;
    logic                    op_ready;
    logic signed [7:0]       act_in;
    logic signed [7:0]       w_in;
    logic [LEN_W-1:0]        mac_index;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [7:0]       result_int8;
    logic                    busy;

    conv_pixel_engine #(
        .MACS_MAX  (MACS_MAX),
        .ACC_W     (ACC_W),
        .SCALE_Q   (SCALE_Q),
        .LEAKY_NUM (LEAKY_NUM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mac_len     (mac_len),
        .act_mode    (act_mode),
        .bias        (bias),
        .scale       (scale),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .act_in      (act_in),
        .w_in        (w_in),
        .mac_index   (mac_index),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result_int8 (result_int8),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int a_arr [MACS_MAX];
    int w_arr [MACS_MAX];
    int n_cmp = 0;
    int n_err = 0;
    int exp_result = 0;
    bit expect_out = 1'b0;
    int last_result = 0;

    task automatic check(input string name, input longint got, input longint want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic longint floor_div(input longint n, input longint d);
        longint q;
        q = n / d;
        if ((n % d) != 0 && n < 0) q = q - 1;
        return q;
    endfunction

    // Reference: dot product, 32-bit wrap with bias, activation, round and saturate.
    function automatic int model(input int len, input int mode, input int bval, input int sval);
        longint acc;
        int     s;
        longint a;
        longint r;
        acc = 0;
        for (int i = 0; i < len; i++) acc += longint'(a_arr[i]) * longint'(w_arr[i]);
        s = int'(acc + longint'(bval));
        a = longint'(s);
        if (s < 0 && mode == 1) a = 0;
        else if (s < 0 && mode == 2) a = floor_div(longint'(s) * longint'(LEAKY_NUM), 128);
        r = floor_div(a * longint'(sval) + 32768, 65536);
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return int'(r);
    endfunction

    task automatic fill_const(input int a, input int w);
        for (int i = 0; i < MACS_MAX; i++) begin
            a_arr[i] = a;
            w_arr[i] = w;
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < MACS_MAX; i++) begin
            a_arr[i] = int'($urandom_range(0, 255)) - 128;
            w_arr[i] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    // Any cycle with a valid result must belong to a live job and match the model.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            check("out_valid_expected", longint'(expect_out), 1);
            check("result", longint'(result_int8), longint'(exp_result));
        end
    end

    task automatic run_job(input int j_len, input int j_mode, input int j_bias, input int j_scale,
                           input bit bubbles, input int stall, input bit poke, input int abort_beat);
        int idx;
        int k;
        int budget;
        int stray;
        bit seen;
        bit beat;
        idx = 0;
        k = 0;
        seen = 1'b0;
        budget = j_len * 4 + 40;
        exp_result = model(j_len, j_mode, j_bias, j_scale);
        @(negedge clk);
        check("idle_before_start", longint'(busy), 0);
        expect_out = 1'b1;
        start    = 1'b1;
        mac_len  = LEN_W'(j_len);
        act_mode = 2'(j_mode);
        bias     = j_bias;
        scale    = 16'(j_scale);
        @(negedge clk);
        k = 1;
        // Scramble job inputs: the engine must work from its latched copies.
        start    = 1'b0;
        mac_len  = LEN_W'($urandom);
        act_mode = 2'($urandom);
        bias     = $urandom;
        scale    = 16'($urandom);
        check("busy_after_start", longint'(busy), 1);
        check("op_ready_after_start", longint'(op_ready), (j_len > 0) ? 1 : 0);
        while (!seen && k < budget) begin
            if (out_valid) begin
                seen = 1'b1;
                last_result = int'(result_int8);
                // Edge count from start to first valid; counting the start cycle gives mac_len+4.
                if (!bubbles) check("latency", longint'(k), longint'(j_len + 3));
                check("mac_index_final", longint'(mac_index), longint'(j_len));
            end else begin
                if (op_ready) check("mac_index", longint'(mac_index), longint'(idx));
                if (abort_beat >= 0 && idx == abort_beat) begin
                    rst = 1'b1;
                    expect_out = 1'b0;
                    op_valid = 1'b0;
                    #1;
                    check("abort_op_ready", longint'(op_ready), 0);
                    check("abort_out_valid", longint'(out_valid), 0);
                    check("abort_busy", longint'(busy), 0);
                    check("abort_result", longint'(result_int8), 0);
                    check("abort_mac_index", longint'(mac_index), 0);
                    repeat (2) @(negedge clk);
                    rst = 1'b0;
                    stray = 0;
                    repeat (40) begin
                        @(negedge clk);
                        if (out_valid) stray++;
                    end
                    check("abort_no_output", longint'(stray), 0);
                    return;
                end
                op_valid = 1'b0;
                act_in   = 8'($urandom);
                w_in     = 8'($urandom);
                if (idx < j_len && op_ready) begin
                    if (!bubbles || $urandom_range(0, 2) != 0) begin
                        op_valid = 1'b1;
                        act_in   = 8'(a_arr[idx]);
                        w_in     = 8'(w_arr[idx]);
                    end
                end else if (idx == j_len) begin
                    op_valid = 1'($urandom_range(0, 1));
                end
                start = poke ? ($urandom_range(0, 3) == 0) : 1'b0;
                beat = op_valid && op_ready;
                @(negedge clk);
                k++;
                if (beat) idx++;
            end
        end
        op_valid = 1'b0;
        if (!seen) begin
            check("out_valid_timeout", 0, 1);
            expect_out = 1'b0;
            start = 1'b0;
            return;
        end
        for (int i = 0; i < stall; i++) begin
            out_ready = 1'b0;
            start = poke ? ($urandom_range(0, 1) == 0) : 1'b0;
            @(negedge clk);
            check("out_valid_held", longint'(out_valid), 1);
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_drop", longint'(out_valid), 0);
        check("busy_drop", longint'(busy), 0);
        expect_out = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int jl;
        int jb;
        rst = 1'b1;
        start = 1'b0;
        mac_len = '0;
        act_mode = '0;
        bias = '0;
        scale = '0;
        op_valid = 1'b0;
        act_in = '0;
        w_in = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_op_ready", longint'(op_ready), 0);
        check("reset_out_valid", longint'(out_valid), 0);
        check("reset_busy", longint'(busy), 0);
        check("reset_result", longint'(result_int8), 0);
        check("reset_mac_index", longint'(mac_index), 0);
        rst = 1'b0;

        // Hand-computed values pin the model before it judges the DUT.
        fill_const(1, 2);
        check("model_pin_leaky64", model(27, 2, 10, SCALE_ONE), 64);
        fill_const(-1, 4);
        check("model_pin_leaky_neg", model(27, 2, 0, SCALE_ONE), -11);
        check("model_pin_relu_neg", model(27, 1, 0, SCALE_ONE), 0);
        fill_const(127, 127);
        check("model_pin_sat_hi", model(27, 0, 0, SCALE_ONE), 127);
        check("model_pin_len0", model(0, 0, -256, 'h8000), -128);

        fill_const(1, 2);
        run_job(27, 2, 10, SCALE_ONE, 0, 0, 0, -1);
        check("dut_leaky64", longint'(last_result), 64);
        fill_const(-1, 4);
        run_job(27, 2, 0, SCALE_ONE, 0, 0, 0, -1);
        check("dut_leaky_neg", longint'(last_result), -11);
        run_job(27, 1, 0, SCALE_ONE, 0, 0, 0, -1);
        check("dut_relu_neg", longint'(last_result), 0);
        fill_const(127, 127);
        run_job(27, 0, 0, SCALE_ONE, 0, 0, 0, -1);
        check("dut_sat_hi", longint'(last_result), 127);
        fill_const(-128, 127);
        run_job(27, 0, 0, SCALE_ONE, 0, 0, 0, -1);
        check("dut_sat_lo", longint'(last_result), -128);
        run_job(0, 0, -256, 'h8000, 0, 0, 0, -1);
        check("dut_len0_linear", longint'(last_result), -128);
        run_job(0, 1, -256, 'h8000, 0, 0, 0, -1);
        check("dut_len0_relu", longint'(last_result), 0);
        run_job(0, 3, -256, 'h8000, 0, 0, 0, -1);
        check("dut_len0_reserved", longint'(last_result), -128);

        // Bubbles, output stall and stray starts must not change the result.
        fill_rand();
        run_job(27, 2, 300, 'h4000, 0, 0, 0, -1);
        r0 = last_result;
        run_job(27, 2, 300, 'h4000, 1, 5, 1, -1);
        check("bubble_same_result", longint'(last_result), longint'(r0));

        // Abort mid-accumulation, then confirm the next job is clean.
        fill_const(1, 2);
        run_job(27, 2, 10, SCALE_ONE, 0, 0, 0, -1);
        run_job(27, 0, 5, SCALE_ONE, 0, 0, 0, 10);
        run_job(27, 2, 10, SCALE_ONE, 0, 0, 0, -1);
        check("after_abort", longint'(last_result), 64);

        for (int j = 0; j < 24; j++) begin
            fill_rand();
            jl = int'($urandom_range(0, 64));
            jb = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 4000)) - 2000;
            run_job(jl, int'($urandom_range(0, 3)), jb, int'($urandom_range(0, 65535)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1);
        end

        fill_rand();
        run_job(MACS_MAX, 0, 0, int'($urandom_range(1, 255)), 0, 2, 1, -1);
        run_job(MACS_MAX, 2, -5000, 'h0800, 1, 0, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
